// File: rtl/mgt_01_ireg_ctx_unit.sv
// Interrupt context save/restore sequencer for the integer register file.
// Build option: define CTX_CALLER_ONLY_EN to transfer only the caller-saved registers.
module mgt_01_ireg_ctx_unit #(
    parameter int XLEN     = 32,
    parameter int WORD_OFF = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clk_en_i,
    input  logic                 save_req_i,
    input  logic                 restore_req_i,
    input  logic [31:0]          base_addr_i,
    input  logic [XLEN*XLEN-1:0] ireg_file_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [XLEN-1:0]      mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [XLEN-1:0]      mem_rdata_i,
    output logic [XLEN*XLEN-1:0] ireg_file_o,
    output logic                 sel_all_o,
    output logic                 inout_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int IDX_W = $clog2(XLEN);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(XLEN - 1);

    // Bit i set means register xi is moved to/from memory.
`ifdef CTX_CALLER_ONLY_EN
    localparam logic [XLEN-1:0] XFER_MASK = XLEN'(32'hF003_FCE2);
`else
    localparam logic [XLEN-1:0] XFER_MASK = ~XLEN'(1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      base_reg;
    logic [XLEN-1:0]  ctx_mem [XLEN];
    logic             xfer_state;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
        logic [IDX_W-1:0] nxt;
        nxt = cur;
        for (int i = XLEN - 1; i > 0; i--) begin
            if (XFER_MASK[i] && (i > int'(cur))) begin
                nxt = IDX_W'(i);
            end
        end
        return nxt;
    endfunction

    assign xfer_state = (state_reg == ST_SAVE) || (state_reg == ST_RESTORE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            base_reg  <= '0;
        end else if (clk_en_i) begin
            case (state_reg)
                ST_IDLE: begin
                    if (save_req_i || restore_req_i) begin
                        state_reg <= save_req_i ? ST_SAVE : ST_RESTORE;
                        base_reg  <= base_addr_i;
                        idx_reg   <= FIRST_IDX;
                    end
                end
                ST_SAVE, ST_RESTORE: begin
                    if (mem_ack_i) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= (state_reg == ST_SAVE) ? ST_DONE : ST_LOAD;
                        end else begin
                            idx_reg <= next_idx(idx_reg);
                        end
                    end
                end
                ST_LOAD: state_reg <= ST_DONE;
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Context buffer is deliberately left out of reset so an aborted restore keeps its data.
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            if ((state_reg == ST_IDLE) && save_req_i) begin
                for (int i = 0; i < XLEN; i++) begin
                    ctx_mem[i] <= ireg_file_i[i*XLEN +: XLEN];
                end
            end else if ((state_reg == ST_RESTORE) && mem_ack_i) begin
                ctx_mem[idx_reg] <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o   = xfer_state;
    assign mem_we_o    = (state_reg == ST_SAVE);
    assign mem_addr_o  = xfer_state ? (base_reg + 32'(WORD_OFF) * 32'(idx_reg)) : 32'h0;
    assign mem_wdata_o = xfer_state ? ctx_mem[idx_reg] : '0;
    assign sel_all_o   = (state_reg == ST_LOAD);
    assign inout_o     = (state_reg == ST_LOAD);
    assign busy_o      = xfer_state || (state_reg == ST_LOAD);
    assign done_o      = (state_reg == ST_DONE);

    // During LOAD, x0 reads as zero and untransferred entries pass the live file through.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_load
            if (gi == 0) begin : g_zero
                assign ireg_file_o[gi*XLEN +: XLEN] = sel_all_o ? '0 : ctx_mem[gi];
            end else if (XFER_MASK[gi]) begin : g_xfer
                assign ireg_file_o[gi*XLEN +: XLEN] = ctx_mem[gi];
            end else begin : g_keep
                assign ireg_file_o[gi*XLEN +: XLEN] =
                    sel_all_o ? ireg_file_i[gi*XLEN +: XLEN] : ctx_mem[gi];
            end
        end
    endgenerate
endmodule
